// File: rtl/full_subtractor.sv
// WIDTH-bit ripple-borrow subtractor: {burrow_fa, difference_fa} = a_fa - b_fa - bur_fa.
// REG_OUT selects combinational outputs or a single registered output stage.
module full_subtractor #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_fa,
    input  logic [WIDTH-1:0] b_fa,
    input  logic             bur_fa,
    output logic [WIDTH-1:0] difference_fa,
    output logic             burrow_fa,
    output logic             zero_fa,
    output logic             out_valid
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_c;
    logic             zero_c;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;
    logic             valid_q;

    always_comb begin
        borrow    = '0;
        diff_c    = '0;
        borrow[0] = bur_fa;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            diff_c[i]     = a_fa[i] ^ b_fa[i] ^ borrow[i];
            borrow[i + 1] = (~a_fa[i] & b_fa[i]) | (~(a_fa[i] ^ b_fa[i]) & borrow[i]);
        end
    end

    assign zero_c = (diff_c == '0);

    // Register stage is always elaborated; the REG_OUT mux below leaves it
    // dangling (and removable) in the combinational configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            diff_q   <= diff_c;
            borrow_q <= borrow[WIDTH];
            zero_q   <= zero_c;
            valid_q  <= in_valid;
        end
    end

    assign difference_fa = REG_OUT ? diff_q   : diff_c;
    assign burrow_fa     = REG_OUT ? borrow_q : borrow[WIDTH];
    assign zero_fa       = REG_OUT ? zero_q   : zero_c;
    assign out_valid     = REG_OUT ? valid_q  : in_valid;

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random checks of full_subtractor in combinational and
// registered configurations at several widths.
module tb_full_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // WIDTH=1, combinational
    logic       v1, a1, b1, bin1, d1, bo1, z1, ov1;
    // WIDTH=4, combinational
    logic       v4, bin4, bo4, z4, ov4;
    logic [3:0] a4, b4, d4;
    // WIDTH=8, registered
    logic       v8, bin8, bo8, z8, ov8;
    logic [7:0] a8, b8, d8;
    // WIDTH=16, combinational
    logic        v16, bin16, bo16, z16, ov16;
    logic [15:0] a16, b16, d16;

    full_subtractor #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a_fa(a1), .b_fa(b1), .bur_fa(bin1),
        .difference_fa(d1), .burrow_fa(bo1), .zero_fa(z1), .out_valid(ov1)
    );
    full_subtractor #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a_fa(a4), .b_fa(b4), .bur_fa(bin4),
        .difference_fa(d4), .burrow_fa(bo4), .zero_fa(z4), .out_valid(ov4)
    );
    full_subtractor #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a_fa(a8), .b_fa(b8), .bur_fa(bin8),
        .difference_fa(d8), .burrow_fa(bo8), .zero_fa(z8), .out_valid(ov8)
    );
    full_subtractor #(.WIDTH(16), .REG_OUT(1'b0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .a_fa(a16), .b_fa(b16), .bur_fa(bin16),
        .difference_fa(d16), .burrow_fa(bo16), .zero_fa(z16), .out_valid(ov16)
    );

    int unsigned vec_count = 0;
    int unsigned err_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hand table for WIDTH=1, index {a,b,bin}, entry {d,bout}
    logic [1:0] w1_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        rst_n = 1'b0;
        {v1, a1, b1, bin1} = '0;
        {v4, a4, b4, bin4} = '0;
        {v8, a8, b8, bin8} = '0;
        {v16, a16, b16, bin16} = '0;

        // Combinational instances are exercised while rst_n is held low.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            {a1, b1, bin1} = abc;
            v1 = abc[0];
            #100;
            check($sformatf("w1_d_%0d", i), 64'(d1), 64'(w1_exp[i][1]));
            check($sformatf("w1_bout_%0d", i), 64'(bo1), 64'(w1_exp[i][0]));
            check($sformatf("w1_ovalid_%0d", i), 64'(ov1), 64'(abc[0]));
        end

        v4 = 1'b1; a4 = 4'd5; b4 = 4'd3; bin4 = 1'b0; #2;
        check("w4_5m3_d", 64'(d4), 64'h2);
        check("w4_5m3_bout", 64'(bo4), 64'h0);
        check("w4_5m3_zero", 64'(z4), 64'h0);
        check("w4_ovalid", 64'(ov4), 64'h1);
        a4 = 4'd3; b4 = 4'd5; bin4 = 1'b0; #2;
        check("w4_3m5_d", 64'(d4), 64'hE);
        check("w4_3m5_bout", 64'(bo4), 64'h1);
        a4 = 4'd0; b4 = 4'd0; bin4 = 1'b1; #2;
        check("w4_0m0m1_d", 64'(d4), 64'hF);
        check("w4_0m0m1_bout", 64'(bo4), 64'h1);
        check("w4_0m0m1_zero", 64'(z4), 64'h0);
        a4 = 4'd7; b4 = 4'd6; bin4 = 1'b1; #2;
        check("w4_7m6m1_d", 64'(d4), 64'h0);
        check("w4_7m6m1_bout", 64'(bo4), 64'h0);
        check("w4_7m6m1_zero", 64'(z4), 64'h1);
        v4 = 1'b0; a4 = 4'd9; b4 = 4'd9; bin4 = 1'b1; #2;
        check("w4_eq_bin_d", 64'(d4), 64'hF);
        check("w4_eq_bin_bout", 64'(bo4), 64'h1);
        check("w4_ovalid_low", 64'(ov4), 64'h0);

        // Registered instance stays cleared under reset despite live inputs.
        v8 = 1'b1; a8 = 8'h55; b8 = 8'h55; bin8 = 1'b0;
        @(posedge clk); #1;
        check("w8_rst_d", 64'(d8), 64'h0);
        check("w8_rst_bout", 64'(bo8), 64'h0);
        check("w8_rst_zero", 64'(z8), 64'h0);
        check("w8_rst_ovalid", 64'(ov8), 64'h0);

        @(negedge clk);
        rst_n = 1'b1; v8 = 1'b0;
        @(posedge clk); #1;
        check("w8_idle_ovalid", 64'(ov8), 64'h0);

        // Latency 1: result not visible until the next rising edge.
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; #1;
        check("w8_pre_ovalid", 64'(ov8), 64'h0);
        check("w8_pre_d", 64'(d8), 64'h0);
        @(posedge clk); #1;
        check("w8_lat_d", 64'(d8), 64'h0F);
        check("w8_lat_bout", 64'(bo8), 64'h0);
        check("w8_lat_zero", 64'(z8), 64'h0);
        check("w8_lat_ovalid", 64'(ov8), 64'h1);

        @(negedge clk);
        a8 = 8'h02; b8 = 8'h05; bin8 = 1'b1;
        @(posedge clk); #1;
        check("w8_uf_d", 64'(d8), 64'hFC);
        check("w8_uf_bout", 64'(bo8), 64'h1);
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h32; bin8 = 1'b1;
        @(posedge clk); #1;
        check("w8_zero_d", 64'(d8), 64'h00);
        check("w8_zero_zero", 64'(z8), 64'h1);
        check("w8_zero_ovalid", 64'(ov8), 64'h1);

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        rst_n = 1'b0; #1;
        check("w8_arst_d", 64'(d8), 64'h0);
        check("w8_arst_zero", 64'(z8), 64'h0);
        check("w8_arst_ovalid", 64'(ov8), 64'h0);
        @(posedge clk); #1;
        check("w8_arst_hold", 64'(ov8), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h20; b8 = 8'h03; bin8 = 1'b1; #1;
        check("w8_rel_ovalid", 64'(ov8), 64'h0);
        @(posedge clk); #1;
        check("w8_rel_d", 64'(d8), 64'h1C);
        check("w8_rel_bout", 64'(bo8), 64'h0);
        check("w8_rel_ovalid", 64'(ov8), 64'h1);

        for (int n = 0; n < 10000; n++) begin
            logic [16:0] model;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            bin16 = 1'($urandom);
            v16 = 1'($urandom);
            if (n % 16 == 0) b16 = a16;
            model = {1'b0, a16} - {1'b0, b16} - {16'b0, bin16};
            #2;
            check("w16_sub", 64'({bo16, d16}), 64'(model));
            check("w16_zero", 64'(z16), 64'(model[15:0] == 16'h0));
            check("w16_ovalid", 64'(ov16), 64'(v16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
